// File: rtl/rb_access_arbiter.sv
// rb_access_arbiter
// Shares the single-port register bank between the receive engine (writer)
// and the transmit engine (reader). All accesses are strictly sequential:
// an IDLE arbitration cycle, then a 1-cycle write or a 2-cycle read
// (address cycle + capture cycle). Every output, including the RB pins, is
// registered.

`timescale 1ns/1ps

module rb_access_arbiter #(
  parameter int AW = 3,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prio_wr,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          RB_RW,
  output logic [AW-1:0] RB_A,
  output logic [DW-1:0] RB_D,
  input  logic [DW-1:0] RB_Q
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR     = 2'd1,
    S_RD     = 2'd2,
    S_RD_CAP = 2'd3
  } state_t;

  // Registered state and outputs
  state_t        r_state;
  logic          r_last_wr;   // 1: last served access was a write
  logic          r_rb_rw;
  logic [AW-1:0] r_rb_a;
  logic [DW-1:0] r_rb_d;
  logic          r_wr_gnt;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;

  // Next-state values
  state_t        w_state_nxt;
  logic          w_last_wr_nxt;
  logic          w_rb_rw_nxt;
  logic [AW-1:0] w_rb_a_nxt;
  logic [DW-1:0] w_rb_d_nxt;
  logic          w_wr_gnt_nxt;
  logic          w_rd_valid_nxt;
  logic [DW-1:0] w_rd_data_nxt;
  logic          w_grant_wr;

  // Write wins when alone, under fixed write priority, or when round-robin
  // says the reader was served last. Reset leaves last=RD, so the first
  // contention after reset goes to the writer.
  assign w_grant_wr = wr_req && (!rd_req || prio_wr || !r_last_wr);

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update together from values computed in the previous cycle.
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_wr  <= 1'b0;
      r_rb_rw    <= 1'b1;
      r_rb_a     <= '0;
      r_rb_d     <= '0;
      r_wr_gnt   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_wr  <= w_last_wr_nxt;
      r_rb_rw    <= w_rb_rw_nxt;
      r_rb_a     <= w_rb_a_nxt;
      r_rb_d     <= w_rb_d_nxt;
      r_wr_gnt   <= w_wr_gnt_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
    end
  end

  // Arbitration, access sequencing and next values of the registered outputs
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    w_state_nxt    = r_state;
    w_last_wr_nxt  = r_last_wr;
    w_rb_rw_nxt    = 1'b1;        // RB rests in read mode outside WR
    w_rb_a_nxt     = r_rb_a;      // address/data hold between accesses
    w_rb_d_nxt     = r_rb_d;
    w_wr_gnt_nxt   = 1'b0;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;   // read data held until the next valid

    unique case (r_state)
      S_IDLE: begin
        // The edge ending IDLE is the only point where requests are seen;
        // `last` is recorded here since a started access always completes
        // unless reset, which clears it anyway.
        if (w_grant_wr) begin
          w_state_nxt   = S_WR;
          w_rb_rw_nxt   = 1'b0;
          w_rb_a_nxt    = wr_addr;
          w_rb_d_nxt    = wr_data;
          w_wr_gnt_nxt  = 1'b1;
          w_last_wr_nxt = 1'b1;
        end else if (rd_req) begin
          w_state_nxt   = S_RD;
          w_rb_a_nxt    = rd_addr;
          w_last_wr_nxt = 1'b0;
        end
      end
      S_WR: begin
        // RB commits the write at the edge ending this cycle.
        w_state_nxt = S_IDLE;
      end
      S_RD: begin
        // RB_Q reflects RB_A during this cycle; capture it at the closing edge.
        w_state_nxt    = S_RD_CAP;
        w_rd_data_nxt  = RB_Q;
        w_rd_valid_nxt = 1'b1;
      end
      S_RD_CAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign wr_gnt   = r_wr_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign RB_RW    = r_rb_rw;
  assign RB_A     = r_rb_a;
  assign RB_D     = r_rb_d;

endmodule

// File: tb/tb_rb_access_arbiter.sv
// tb_rb_access_arbiter
// Directed scenarios followed by randomized requester traffic. Expected
// pin activity comes from a transaction-level reference: each arbitration
// win is expanded into a queue of per-cycle expected output snapshots.

`timescale 1ns/1ps

module tb_rb_access_arbiter;

  localparam int AW = 3;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prio_wr = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          RB_RW;
  logic [AW-1:0] RB_A;
  logic [DW-1:0] RB_D;
  logic [DW-1:0] RB_Q;

  int n_checks = 0;
  int n_pass   = 0;

  rb_access_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .prio_wr(prio_wr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .RB_Q(RB_Q)
  );

  always #5 clk = ~clk;

  // Register bank: combinational read of the presented address, write at
  // the rising edge while RB_RW=0.
  logic [DW-1:0] rb_mem [2**AW];
  assign RB_Q = rb_mem[RB_A];
  always @(posedge clk) if (!RB_RW) rb_mem[RB_A] <= RB_D;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          idle;
    logic          is_wr;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          gnt;
    logic          valid;
    logic [DW-1:0] q;
  } snap_t;

  snap_t         exp_s;
  snap_t         cur_s;
  snap_t         tmp_s;
  snap_t         sched[$];
  logic [DW-1:0] m_mem [2**AW];
  logic          m_last_wr;
  logic          m_pick_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      exp_s     = '{idle: 1'b1, rw: 1'b1, default: '0};
      m_last_wr = 1'b0;
    end else begin
      cur_s = exp_s;
      if (cur_s.is_wr) m_mem[cur_s.a] = cur_s.d;
      if (cur_s.idle && (wr_req || rd_req)) begin
        if (wr_req && rd_req) m_pick_w = prio_wr ? 1'b1 : !m_last_wr;
        else                  m_pick_w = wr_req;
        m_last_wr = m_pick_w;
        tmp_s = cur_s;
        tmp_s.idle = 1'b0;
        if (m_pick_w) begin
          tmp_s.is_wr = 1'b1; tmp_s.rw = 1'b0;
          tmp_s.a = wr_addr;  tmp_s.d = wr_data; tmp_s.gnt = 1'b1;
          sched.push_back(tmp_s);
        end else begin
          tmp_s.a = rd_addr;
          sched.push_back(tmp_s);
          tmp_s.valid = 1'b1;
          tmp_s.q = m_mem[rd_addr];
          sched.push_back(tmp_s);
        end
      end
      if (sched.size() > 0) exp_s = sched.pop_front();
      else begin
        exp_s = cur_s;
        exp_s.idle = 1'b1; exp_s.is_wr = 1'b0; exp_s.rw = 1'b1;
        exp_s.gnt = 1'b0;  exp_s.valid = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("rb_rw",    32'(RB_RW),    32'(exp_s.rw));
      check("rb_a",     32'(RB_A),     32'(exp_s.a));
      check("rb_d",     32'(RB_D),     32'(exp_s.d));
      check("wr_gnt",   32'(wr_gnt),   32'(exp_s.gnt));
      check("rd_valid", 32'(rd_valid), 32'(exp_s.valid));
      check("rd_data",  32'(rd_data),  32'(exp_s.q));
    end
  end

  // ---------------- helpers ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_rw"},    32'(RB_RW),    32'h1);
    check({tag, "_a"},     32'(RB_A),     32'h0);
    check({tag, "_d"},     32'(RB_D),     32'h0);
    check({tag, "_gnt"},   32'(wr_gnt),   32'h0);
    check({tag, "_valid"}, 32'(rd_valid), 32'h0);
    check({tag, "_rdata"}, 32'(rd_data),  32'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!exp_s.idle && n < 20);
    if (!exp_s.idle) begin
      n_checks++;
      $display("FAIL idle_wait: timed out after %0d cycles, required idle", n);
    end else begin
      check("idle_rw", 32'(RB_RW), 32'h1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt_w, cnt_r, n, got;
    logic [7:0] order[$];

    for (int i = 0; i < 2**AW; i++) begin
      rb_mem[i] = 18'($urandom);
      m_mem[i]  = rb_mem[i];
    end

    // Power-on reset
    #1 rst = 1'b1;
    #1 check_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single write: addr 5, data 2A5A5
    wait_idle();
    prio_wr = 1'b1;
    wr_req = 1'b1; wr_addr = 3'd5; wr_data = 18'h2A5A5;
    @(negedge clk);
    check("t2_rw",  32'(RB_RW),  32'h0);
    check("t2_a",   32'(RB_A),   32'h5);
    check("t2_d",   32'(RB_D),   32'h2A5A5);
    check("t2_gnt", 32'(wr_gnt), 32'h1);
    wr_req = 1'b0;
    @(negedge clk);
    check("t2_gnt_1cyc", 32'(wr_gnt), 32'h0);
    check("t2_rw_back",  32'(RB_RW),  32'h1);

    // Read back the same address
    rd_req = 1'b1; rd_addr = 3'd5;
    @(negedge clk);
    check("t3_rw",    32'(RB_RW),    32'h1);
    check("t3_a",     32'(RB_A),     32'h5);
    check("t3_valid0", 32'(rd_valid), 32'h0);
    @(negedge clk);
    check("t3_valid", 32'(rd_valid), 32'h1);
    check("t3_data",  32'(rd_data),  32'h2A5A5);
    rd_req = 1'b0;
    @(negedge clk);
    check("t3_valid_1cyc", 32'(rd_valid), 32'h0);
    check("t3_data_hold",  32'(rd_data),  32'h2A5A5);

    // Round-robin under continuous contention: W,R,W,R,...
    wait_idle();
    prio_wr = 1'b0;
    wr_req = 1'b1; wr_addr = 3'd2; wr_data = 18'h11111;
    rd_req = 1'b1; rd_addr = 3'd2;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      check("t4_no_double", 32'(wr_gnt & rd_valid), 32'h0);
      if (wr_gnt) begin
        check("t4_wr_rw0", 32'(RB_RW), 32'h0);
        order.push_back("W");
      end
      if (rd_valid) order.push_back("R");
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("t4_count", 32'(order.size() >= 8), 32'h1);
    for (int i = 0; i < order.size(); i++)
      check("t4_order", 32'(order[i]), (i % 2 == 0) ? 32'("W") : 32'("R"));
    wait_idle();
    wait_idle();

    // Fixed write priority starves reads while writes keep coming
    prio_wr = 1'b1;
    wr_req = 1'b1; wr_addr = 3'd7; wr_data = 18'h3C3C3;
    rd_req = 1'b1; rd_addr = 3'd7;
    cnt_w = 0; cnt_r = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_gnt)   cnt_w++;
      if (rd_valid) cnt_r++;
    end
    check("t5_wr_gnts", 32'(cnt_w), 32'd5);
    check("t5_no_read", 32'(cnt_r), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_gnt && n < 3);
    check("t5_last_gnt", 32'(wr_gnt), 32'h1);
    wr_req = 1'b0;
    got = 0;
    for (int c = 0; c < 3 && got == 0; c++) begin
      @(negedge clk);
      if (rd_valid) got = 1;
    end
    check("t5_rd_within3", 32'(got), 32'h1);
    check("t5_rd_data", 32'(rd_data), 32'h3C3C3);
    rd_req = 1'b0;

    // Reset during a read: no valid, data cleared
    wait_idle();
    rd_req = 1'b1; rd_addr = 3'd5;
    @(negedge clk);
    check("t6_in_rd", 32'(RB_A), 32'h5);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_rst");
    rd_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t6_no_valid", 32'(rd_valid), 32'h0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_idle_rw",    32'(RB_RW),    32'h1);
      check("t6_idle_valid", 32'(rd_valid), 32'h0);
      check("t6_idle_rdata", 32'(rd_data),  32'h0);
    end

    // Reset during a write: the write is abandoned
    wr_req = 1'b1; wr_addr = 3'd5; wr_data = 18'h00FF0;
    @(negedge clk);
    check("t1_in_wr", 32'(wr_gnt), 32'h1);
    #2 rst = 1'b1;
    #1 check_reset_vals("t1_rst");
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b1; rd_addr = 3'd5;
    repeat (2) @(negedge clk);
    check("t1_abandoned", 32'(rd_data), 32'h2A5A5);
    rd_req = 1'b0;

    // Randomized traffic with occasional resets
    repeat (1500) begin
      @(negedge clk);
      if (rst) begin
        if ($urandom_range(0, 2) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        wr_req = 1'b0; rd_req = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("rnd_rst");
      end else begin
        if (wr_gnt) wr_req = 1'b0;
        else if (!wr_req && $urandom_range(0, 2) == 0) begin
          wr_req  = 1'b1;
          wr_addr = AW'($urandom_range(0, 2**AW - 1));
          wr_data = DW'($urandom);
        end
        if (rd_valid) rd_req = 1'b0;
        else if (!rd_req && $urandom_range(0, 2) == 0) begin
          rd_req  = 1'b1;
          rd_addr = AW'($urandom_range(0, 2**AW - 1));
        end
        if ($urandom_range(0, 15) == 0) prio_wr = ~prio_wr;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
